// File: rtl/redirect_ctrl.sv
// Control-flow redirect controller: arbitrates branch/jump/trap requests into a
// registered PC-select and per-stage flush, with stall holding and event counters.
module redirect_ctrl #(
    parameter int NSTAGE   = 4,
    parameter int TRAP_CYC = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken,
    input  logic              jal,
    input  logic              jalr,
    input  logic              trap,
    input  logic              stall_in,
    output logic [2:0]        pc_sel,
    output logic [NSTAGE-1:0] flush,
    output logic              busy,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  jmp_cnt,
    output logic [CNT_W-1:0]  trap_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        TRAPF = 2'd2
    } state_t;

    // Request codes are ordered by priority so a plain magnitude compare arbitrates.
    localparam logic [2:0] R_NONE = 3'd0;
    localparam logic [2:0] R_JAL  = 3'd1;
    localparam logic [2:0] R_JALR = 3'd2;
    localparam logic [2:0] R_BR   = 3'd3;
    localparam logic [2:0] R_TRAP = 3'd4;

    localparam logic [3:0]        TRAP_LOAD = 4'(TRAP_CYC);
    localparam logic [NSTAGE-1:0] FL_ALL    = '1;
    localparam logic [NSTAGE-1:0] FL_JMP    = NSTAGE'(1);
    localparam logic [NSTAGE-1:0] FL_BR     = NSTAGE'(3);

    state_t            state_reg, state_next;
    logic [2:0]        pend_reg, pend_next;
    logic [3:0]        tcnt_reg, tcnt_next;
    logic [2:0]        sel_reg, sel_next;
    logic [NSTAGE-1:0] flush_reg, flush_next;
    logic [2:0]        new_req;
    logic [2:0]        win_req;
    logic [2:0]        issue;
    logic [2:0]        inc;
    logic [2:0][CNT_W-1:0] cnt_vec;

    always_comb begin
        new_req = R_NONE;
        if (trap)          new_req = R_TRAP;
        else if (br_taken) new_req = R_BR;
        else if (jalr)     new_req = R_JALR;
        else if (jal)      new_req = R_JAL;
    end

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        tcnt_next  = tcnt_reg;
        issue      = R_NONE;
        sel_next   = 3'd0;
        flush_next = '0;
        win_req    = (new_req > pend_reg) ? new_req : pend_reg;

        case (state_reg)
            IDLE: begin
                if (new_req != R_NONE) begin
                    if (stall_in) begin
                        pend_next  = new_req;
                        state_next = HOLD;
                    end else begin
                        issue = new_req;
                    end
                end
            end
            HOLD: begin
                if (stall_in) begin
                    pend_next = win_req;
                end else begin
                    issue      = win_req;
                    pend_next  = R_NONE;
                    state_next = IDLE;
                end
            end
            TRAPF: begin
                // Stalls and lesser requests are swallowed while the trap flush drains.
                if (trap) begin
                    issue = R_TRAP;
                end else begin
                    tcnt_next = tcnt_reg - 4'd1;
                    if (tcnt_reg <= 4'd1) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (issue == R_TRAP) begin
            state_next = TRAPF;
            tcnt_next  = TRAP_LOAD;
        end

        case (issue)
            R_BR:    begin sel_next = 3'd1; flush_next = FL_BR;  end
            R_JAL:   begin sel_next = 3'd2; flush_next = FL_JMP; end
            R_JALR:  begin sel_next = 3'd3; flush_next = FL_JMP; end
            R_TRAP:  begin sel_next = 3'd4; flush_next = FL_ALL; end
            default: flush_next = (state_next == TRAPF) ? FL_ALL : '0;
        endcase

        inc[0] = (issue == R_BR);
        inc[1] = (issue == R_JAL) || (issue == R_JALR);
        inc[2] = (issue == R_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pend_reg  <= R_NONE;
            tcnt_reg  <= 4'd0;
            sel_reg   <= 3'd0;
            flush_reg <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            tcnt_reg  <= tcnt_next;
            sel_reg   <= sel_next;
            flush_reg <= flush_next;
        end
    end

    // Saturating event counters: 0 = branch, 1 = jal/jalr, 2 = trap.
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_reg <= '0;
            end else if (inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
        assign cnt_vec[gi] = cnt_reg;
    end

    assign pc_sel   = sel_reg;
    assign flush    = flush_reg;
    assign busy     = (state_reg != IDLE);
    assign br_cnt   = cnt_vec[0];
    assign jmp_cnt  = cnt_vec[1];
    assign trap_cnt = cnt_vec[2];

endmodule
